barramento_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the 128-bit I/O bus (barramento) between N_REQ requesters.
- Grants one requester at a time for a burst of up to MAX_BURST beats.
- Registers the winning beat onto a single valid/data output that drives the bus data_in/valid_in.
- Releases the bus on last beat, on beat-count exhaustion, or on a stall timeout.

---
 rtl/barramento_arb.sv | 182 ++++++++++++++++++
 tb/tb_barramento_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barramento_arb.sv
// ---------------------------------------------------------------------------
// barramento_arb
//
// Round-robin arbiter and beat sequencer that shares the 128-bit I/O bus
// (barramento) between N_REQ requesters. One requester at a time is granted
// a burst of up to MAX_BURST beats. Each accepted beat is registered onto a
// single valid/data output that feeds the bus valid_in/data_in. The grant is
// released on a last-flagged beat, when the beat budget is used up, or after
// STALL_MAX consecutive cycles in which no beat was accepted.
//
// Ports:
//   clk        in   1              system clock, rising edge
//   reset      in   1              synchronous, active-high reset
//   req_valid  in   N_REQ          per-requester beat valid
//   req_last   in   N_REQ          per-requester last-beat flag (with req_valid)
//   req_data   in   N_REQ*DATA_W   requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  N_REQ          per-requester accept, one-hot or zero
//   out_ready  in   1              downstream accept (tie 1 on the bus)
//   out_valid  out  1              registered beat valid
//   out_data   out  DATA_W         registered beat data
//   grant_id   out  clog2(N_REQ)   current or most recent grant index
//   busy       out  1              high while a burst grant is held
// ---------------------------------------------------------------------------
module barramento_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 128,
    parameter int MAX_BURST = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int GID_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state;
    logic [GID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [7:0]        stall_cnt;

    logic [DATA_W-1:0] req_beat [N_REQ];

    logic              accept_en_p0;
    logic              beat_acc_p0;
    logic              rel_last_p0;
    logic              rel_cap_p0;
    logic              rel_stall_p0;
    logic              release_p0;
    logic [GID_W-1:0]  winner_p0;

    logic              beat_vld_p1;
    logic [DATA_W-1:0] beat_data_p1;

    // First requester with a pending beat, scanning upward from ptr and
    // wrapping at N_REQ.
    function automatic logic [GID_W-1:0] pick_winner(
        input logic [N_REQ-1:0] vld,
        input logic [GID_W-1:0] ptr
    );
        logic [GID_W-1:0] win;
        logic [GID_W-1:0] idx;
        logic             found;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = GID_W'((int'(ptr) + i) % N_REQ);
            if (!found && vld[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [GID_W-1:0] next_idx(input logic [GID_W-1:0] cur);
        logic [GID_W-1:0] nxt;
        if (cur == GID_W'(N_REQ - 1)) begin
            nxt = '0;
        end else begin
            nxt = cur + 1'b1;
        end
        return nxt;
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_beat
        assign req_beat[i] = req_data[i*DATA_W +: DATA_W];
    end

    // ---- Stage p0: grant selection, handshake and release decision ----
    always_comb begin
        accept_en_p0 = !beat_vld_p1 || out_ready;
        req_ready    = '0;
        if (state == BURST) begin
            req_ready[grant_id] = accept_en_p0;
        end
        beat_acc_p0  = (state == BURST) && req_valid[grant_id] && accept_en_p0;
        rel_last_p0  = beat_acc_p0 && req_last[grant_id];
        rel_cap_p0   = beat_acc_p0 && ((int'(beat_cnt) + 1) == MAX_BURST);
        // stall_cnt counts the no-accept cycles already seen, so this cycle
        // is the STALL_MAX-th one when it equals STALL_MAX-1.
        rel_stall_p0 = (state == BURST) && !beat_acc_p0 &&
                       (int'(stall_cnt) == (STALL_MAX - 1));
        release_p0   = rel_last_p0 || rel_cap_p0 || rel_stall_p0;
        winner_p0    = pick_winner(req_valid, rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state     <= BURST;
                        busy      <= 1'b1;
                        grant_id  <= winner_p0;
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                BURST: begin
                    if (beat_acc_p0) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + 8'd1;
                    end
                    // grant_id is left untouched so it still names the
                    // requester that just finished.
                    if (release_p0) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_idx(grant_id);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---- Stage p1: output beat register ----
    // Drains independently of the FSM so a beat taken on the release edge
    // is still presented until the bus accepts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_vld_p1  <= 1'b0;
            beat_data_p1 <= '0;
        end else if (beat_acc_p0) begin
            beat_vld_p1  <= 1'b1;
            beat_data_p1 <= req_beat[grant_id];
        end else if (out_ready) begin
            beat_vld_p1  <= 1'b0;
        end
    end

    assign out_valid = beat_vld_p1;
    assign out_data  = beat_data_p1;

endmodule

// File: tb/tb_barramento_arb.sv
// ---------------------------------------------------------------------------
// tb_barramento_arb
//
// Directed bench for barramento_arb. Requesters are modelled as beat queues
// that present their head beat and pop it on a handshake. A transaction-level
// model of the arbiter predicts the outputs each cycle; hand-computed literal
// expectations pin the model at key points of each scenario.
// ---------------------------------------------------------------------------
module tb_barramento_arb;

    localparam int N  = 4;
    localparam int DW = 128;
    localparam int MB = 4;
    localparam int SM = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      grant_id;
    logic            busy;

    barramento_arb #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .MAX_BURST(MB),
        .STALL_MAX(SM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- requester sources ----------------
    logic [DW:0]  srcq [N][$];
    logic [N-1:0] src_en = '0;
    logic [N-1:0] hs     = '0;

    always @(negedge clk) hs <= req_valid & req_ready & {N{!reset}};

    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && srcq[i].size() > 0) srcq[i].delete(0);
                if (src_en[i] && srcq[i].size() > 0) begin
                    req_valid[i]            = 1'b1;
                    req_last[i]             = srcq[i][0][DW];
                    req_data[i*DW +: DW]    = srcq[i][0][DW-1:0];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    task automatic push(input int r, input logic last, input logic [DW-1:0] d);
        srcq[r].push_back({last, d});
    endtask

    // ---------------- behavioural model ----------------
    // Counts down a beat budget and a patience budget per grant.
    bit            model_ok = 1'b0;
    bit            m_busy   = 1'b0;
    bit            m_ov     = 1'b0;
    int            m_gid    = 0;
    int            m_rr     = 0;
    int            m_left   = 0;
    int            m_pat    = 0;
    logic [DW-1:0] m_od     = '0;

    task automatic model_step();
        bit            take, nb, nov;
        int            ng, nrr, nl, np;
        logic [DW-1:0] nod;
        bit            found;
        nb = m_busy; nov = m_ov; ng = m_gid; nrr = m_rr; nl = m_left; np = m_pat; nod = m_od;
        if (reset) begin
            nb = 0; nov = 0; ng = 0; nrr = 0; nl = 0; np = 0; nod = '0;
        end else begin
            take = m_busy && req_valid[m_gid] && (!m_ov || out_ready);
            if (take) begin
                nov = 1;
                nod = req_data[m_gid*DW +: DW];
            end else if (out_ready) begin
                nov = 0;
            end
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_valid[(m_rr + k) % N]) begin
                        found = 1;
                        ng = (m_rr + k) % N;
                        nb = 1; nl = MB; np = SM;
                    end
                end
            end else if (take) begin
                nl = m_left - 1;
                np = SM;
                if (req_last[m_gid] || nl == 0) begin
                    nb = 0; nrr = (m_gid + 1) % N;
                end
            end else begin
                np = m_pat - 1;
                if (np == 0) begin
                    nb = 0; nrr = (m_gid + 1) % N;
                end
            end
        end
        m_busy <= nb; m_ov <= nov; m_gid <= ng; m_rr <= nrr;
        m_left <= nl; m_pat <= np; m_od <= nod;
        if (reset) model_ok <= 1'b1;
    endtask

    always @(posedge clk) model_step();

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_busy && (!m_ov || out_ready)) r[m_gid] = 1'b1;
        return r;
    endfunction

    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } ent_t;
    ent_t dlog[$];

    always @(negedge clk) begin
        if (model_ok) begin
            chk("out_valid", DW'(out_valid), DW'(m_ov));
            chk("out_data",  out_data,       m_od);
            chk("busy",      DW'(busy),      DW'(m_busy));
            chk("grant_id",  DW'(grant_id),  DW'(m_gid));
            chk("req_ready", DW'(req_ready), DW'(model_ready()));
            if (out_valid && out_ready) dlog.push_back('{cyc, out_data});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        src_en    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) srcq[i].delete();
        tick();
        reset = 1'b0;
        dlog.delete();
        tick();
    endtask

    logic [DW-1:0] d1, fe, p1, p2, p3, p4, p5;

    initial begin
        d1 = 128'h1234567890ABCDEF1234567890ABCDEF;
        fe = 128'hFEDCBA0987654321FEDCBA0987654321;
        p1 = {32{4'h1}}; p2 = {32{4'h2}}; p3 = {32{4'h3}}; p4 = {32{4'h4}}; p5 = {32{4'h5}};
        reset     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data",  out_data,       '0);
        chk("rst_busy",      DW'(busy),      '0);
        chk("rst_grant_id",  DW'(grant_id),  '0);
        chk("rst_req_ready", DW'(req_ready), '0);
        reset = 1'b0;
        tick();

        // Single requester: busy at T+1, beat out at T+2 for one cycle.
        push(0, 1'b1, d1);
        src_en[0] = 1'b1;
        tick();
        chk("single_busy_t1",  DW'(busy),      DW'(1));
        chk("single_ready_t1", DW'(req_ready), DW'(4'b0001));
        chk("single_ov_t1",    DW'(out_valid), '0);
        tick();
        chk("single_ov_t2",    DW'(out_valid), DW'(1));
        chk("single_od_t2",    out_data,       d1);
        chk("single_busy_t2",  DW'(busy),      '0);
        tick();
        chk("single_ov_t3",    DW'(out_valid), '0);

        // rr_ptr is now 1: requester 1 wins over requester 0.
        push(0, 1'b1, p5);
        push(1, 1'b1, p4);
        src_en[1] = 1'b1;
        tick();
        chk("rr_grant", DW'(grant_id), DW'(1));
        chk("rr_busy",  DW'(busy),     DW'(1));
        repeat (8) tick();

        // Fairness: order 0,1,2,3,0 with one idle cycle between beats.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            push(0, 1'b1, p1); push(1, 1'b1, p2); push(2, 1'b1, p3); push(3, 1'b1, p4);
        end
        src_en = 4'hF;
        repeat (24) tick();
        chk("fair_count", DW'(dlog.size()), DW'(8));
        if (dlog.size() >= 5) begin
            chk("fair_b0", dlog[0].d, p1);
            chk("fair_b1", dlog[1].d, p2);
            chk("fair_b2", dlog[2].d, p3);
            chk("fair_b3", dlog[3].d, p4);
            chk("fair_b4", dlog[4].d, p1);
            for (int k = 0; k < 4; k++)
                chk("fair_gap", DW'(dlog[k+1].c - dlog[k].c), DW'(2));
        end

        // Burst cap: 6 beats, no last -> 4 back-to-back, idle, then 2 more.
        do_reset();
        for (int k = 0; k < 6; k++) push(2, 1'b0, p5);
        src_en[2] = 1'b1;
        repeat (24) tick();
        chk("cap_count", DW'(dlog.size()), DW'(6));
        if (dlog.size() == 6) begin
            chk("cap_first4_span", DW'(dlog[3].c - dlog[0].c), DW'(3));
            chk("cap_regrant_gap", DW'(dlog[4].c - dlog[3].c), DW'(2));
            chk("cap_data",        dlog[5].d,                  p5);
        end

        // Backpressure: output holds for 3 cycles, req_ready low meanwhile.
        do_reset();
        push(3, 1'b0, fe);
        push(3, 1'b0, p1);
        push(3, 1'b1, p2);
        src_en[3] = 1'b1;
        tick();
        chk("bp_busy", DW'(busy), DW'(1));
        tick();
        chk("bp_ov_first", DW'(out_valid), DW'(1));
        chk("bp_od_first", out_data,       fe);
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_hold_ov",    DW'(out_valid), DW'(1));
            chk("bp_hold_od",    out_data,       fe);
            chk("bp_hold_ready", DW'(req_ready), '0);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        chk("bp_count", DW'(dlog.size()), DW'(3));
        if (dlog.size() == 3) begin
            chk("bp_b0", dlog[0].d, fe);
            chk("bp_b1", dlog[1].d, p1);
            chk("bp_b2", dlog[2].d, p2);
        end

        // Stall timeout: requester 1 withdraws, released after 8 cycles.
        do_reset();
        push(1, 1'b1, p3);
        push(3, 1'b1, p4);
        src_en = 4'b1010;
        tick();
        chk("stall_grant1", DW'(grant_id), DW'(1));
        src_en[1] = 1'b0;
        repeat (7) begin
            tick();
            chk("stall_still_busy", DW'(busy), DW'(1));
        end
        tick();
        chk("stall_released", DW'(busy), '0);
        tick();
        chk("stall_grant3", DW'(grant_id), DW'(3));
        chk("stall_busy3",  DW'(busy),     DW'(1));
        src_en[1] = 1'b1;
        repeat (12) tick();

        // Reset mid-burst during beat 2.
        do_reset();
        push(0, 1'b0, p1);
        push(0, 1'b0, p2);
        push(0, 1'b0, p3);
        push(0, 1'b0, p4);
        src_en[0] = 1'b1;
        tick();
        tick();
        chk("mid_ov_beat1", DW'(out_valid), DW'(1));
        reset = 1'b1;
        tick();
        chk("mid_ov",    DW'(out_valid), '0);
        chk("mid_od",    out_data,       '0);
        chk("mid_busy",  DW'(busy),      '0);
        chk("mid_gid",   DW'(grant_id),  '0);
        chk("mid_ready", DW'(req_ready), '0);
        reset = 1'b0;
        dlog.delete();
        push(1, 1'b1, p5);
        src_en[1] = 1'b1;
        tick();
        chk("mid_restart_gid",  DW'(grant_id), '0);
        chk("mid_restart_busy", DW'(busy),     DW'(1));
        repeat (20) tick();
        chk("mid_count", DW'(dlog.size()), DW'(4));
        if (dlog.size() == 4) begin
            chk("mid_b0", dlog[0].d, p2);
            chk("mid_b3", dlog[3].d, p5);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
